// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver: prescaled digit stepping, frame-synchronous
// data update, hex decode. Optional leading-zero blanking when SEG_LZ_BLANK_EN is defined.
module seg_scan_driver #(
    parameter int N   = 8,
    parameter int K   = 3,
    parameter int DIV = 100000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [4*N-1:0]   data_in,
    output logic [N-1:0]     an,
    output logic [6:0]       seg,
    output logic             frame_done
);

    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [PW-1:0]  r_presc;
    logic [K-1:0]   r_idx;
    logic [4*N-1:0] r_disp;
    logic [4*N-1:0] r_pend;
    logic           r_pend_valid;
    logic [N-1:0]   r_an;
    logic [6:0]     r_seg;
    logic           r_frame_done;

    logic           w_tick;
    logic           w_last;
    logic           w_wrap;
    logic [3:0]     w_nib;
    logic [N-1:0]   w_an;
    logic [6:0]     w_seg;

    // Active-low hex decode, segment order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            4'hF:    s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

`ifdef SEG_LZ_BLANK_EN
    // A digit is blank when it sits above the most significant nonzero nibble; digit 0 never is
    function automatic logic lz_blank(input logic [4*N-1:0] d, input logic [K-1:0] idx);
        logic [K-1:0] hi;
        hi = '0;
        for (int i = 0; i < N; i++) begin
            if (d[4*i +: 4] != 4'h0) begin
                hi = K'(i);
            end
        end
        return (idx > hi);
    endfunction
`endif

    assign w_tick = (r_presc == PW'(DIV - 1));
    assign w_last = (r_idx == K'(N - 1));
    assign w_wrap = w_tick && w_last;
    assign w_nib  = r_disp[{r_idx, 2'b00} +: 4];

    // Next-cycle digit enable and segment pattern for the current scan slot
    always_comb begin
        w_an = '1;
        for (int i = 0; i < N; i++) begin
            if (r_idx == K'(i)) begin
                w_an[i] = 1'b0;
            end else begin
                w_an[i] = 1'b1;
            end
        end
`ifdef SEG_LZ_BLANK_EN
        if (lz_blank(r_disp, r_idx)) begin
            w_seg = 7'h7F;
        end else begin
            w_seg = hex_to_seg(w_nib);
        end
`else
        w_seg = hex_to_seg(w_nib);
`endif
    end

    // Prescaler and scan index
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_idx   <= w_last ? '0 : r_idx + K'(1);
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Pending buffer; the display only changes on a frame boundary so a frame never mixes data
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_disp       <= '0;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
        end else if (w_wrap) begin
            if (load) begin
                r_disp <= data_in;
            end else if (r_pend_valid) begin
                r_disp <= r_pend;
            end else begin
                r_disp <= r_disp;
            end
            r_pend_valid <= 1'b0;
        end else if (load) begin
            r_pend       <= data_in;
            r_pend_valid <= 1'b1;
        end else begin
            r_pend_valid <= r_pend_valid;
        end
    end

    // Registered outputs
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_an         <= '1;
            r_seg        <= 7'h7F;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= w_an;
            r_seg        <= w_seg;
            r_frame_done <= w_wrap;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (N=8, DIV=4). Expectations follow SEG_LZ_BLANK_EN if defined.
module tb_seg_scan_driver;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        load = 1'b0;
    logic [31:0] data_in = 32'h0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        frame_done;

    int n_chk = 0;
    int n_err = 0;
    int s = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg_scan_driver #(.N(8), .K(3), .DIV(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .load       (load),
        .data_in    (data_in),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at step %0d: got 0x%02h expected 0x%02h", tag, s, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        s++;
    endtask

    task automatic step_to(input int target);
        while (s < target) step();
    endtask

    // digit shown on the outputs after step number st since reset release
    function automatic int shown(input int st);
        return ((st - 1) / 4) % 8;
    endfunction

    // expected pattern for a digit of an all-zero display
    function automatic logic [7:0] zexp(input int d);
`ifdef SEG_LZ_BLANK_EN
        return (d == 0) ? 8'h40 : 8'h7F;
`else
        return 8'h40;
`endif
    endfunction

    function automatic logic [7:0] an_exp(input int d);
        logic [7:0] e;
        e = 8'hFF;
        e[d] = 1'b0;
        return e;
    endfunction

    initial begin
        logic [7:0] e;
        // reset
        repeat (3) step();
        chk("rst_an", an, 8'hFF);
        chk("rst_seg", {1'b0, seg}, 8'h7F);
        chk("rst_fd", {7'b0, frame_done}, 8'h00);
        RST = 1'b1;
        s = 0;

        // free-running scan over 40 cycles
        for (int k = 0; k < 40; k++) begin
            step();
            chk("scan_an", an, an_exp(shown(s)));
            chk("scan_fd", {7'b0, frame_done}, (s % 32 == 0) ? 8'h01 : 8'h00);
            chk("scan_seg", {1'b0, seg}, zexp(shown(s)));
        end

        // load mid-frame at index 3: old data until the wrap
        step_to(44);
        data_in = 32'h76543210; load = 1'b1;
        step();
        load = 1'b0;
        chk("ld_pv", {7'b0, dut.r_pend_valid}, 8'h01);
        while (s < 96) begin
            step();
            e = (s <= 64) ? zexp(shown(s)) : {1'b0, seg_tab[shown(s)]};
            chk("ld_seg", {1'b0, seg}, e);
        end

        // load coincident with a wrap tick
        step_to(127);
        data_in = 32'hFEDCBA98; load = 1'b1;
        step();
        load = 1'b0;
        chk("wrapld_pv", {7'b0, dut.r_pend_valid}, 8'h00);
        while (s < 160) begin
            step();
            chk("wrapld_seg", {1'b0, seg}, {1'b0, seg_tab[8 + shown(s)]});
        end

        // two loads in one frame: last wins
        step_to(164);
        data_in = 32'h11111111; load = 1'b1;
        step();
        load = 1'b0;
        step_to(169);
        data_in = 32'h22222222; load = 1'b1;
        step();
        load = 1'b0;
        step_to(180);
        chk("twold_old", {1'b0, seg}, 8'h46);
        step_to(192);
        while (s < 224) begin
            step();
            chk("twold_seg", {1'b0, seg}, 8'h24);
        end

        // reset mid-frame at index 5 with a pending load
        step_to(226);
        data_in = 32'h33333333; load = 1'b1;
        step();
        load = 1'b0;
        chk("rstmid_pv1", {7'b0, dut.r_pend_valid}, 8'h01);
        step_to(244);
        RST = 1'b0;
        step();
        chk("rstmid_an", an, 8'hFF);
        chk("rstmid_seg", {1'b0, seg}, 8'h7F);
        chk("rstmid_fd", {7'b0, frame_done}, 8'h00);
        chk("rstmid_pv", {7'b0, dut.r_pend_valid}, 8'h00);
        RST = 1'b1;
        s = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            chk("rstmid_an2", an, an_exp(shown(s)));
            chk("rstmid_seg2", {1'b0, seg}, zexp(shown(s)));
        end

        // sparse value: leading digits blank only in the blanking build
        data_in = 32'h00000305; load = 1'b1;
        step();
        load = 1'b0;
        step_to(64);
        while (s < 96) begin
            step();
            case (shown(s))
                0:       e = 8'h12;
                1:       e = 8'h40;
                2:       e = 8'h30;
`ifdef SEG_LZ_BLANK_EN
                default: e = 8'h7F;
`else
                default: e = 8'h40;
`endif
            endcase
            chk("lz_seg", {1'b0, seg}, e);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter N, default 8: number of 7-segment digits scanned.
REQ-002 SHALL have parameter K, default 3: scan index width, ceil(log2 N).
REQ-003 SHALL have parameter DIV, default 100000: CLK cycles per digit slot, DIV >= 2.
REQ-004 SHALL have port CLK  input  1: single clock, all logic on rising edge.
REQ-005 SHALL have port RST  input  1: reset, synchronous, active-low.
REQ-006 SHALL have port load  input  1: when 1, capture data_in this cycle.
REQ-007 SHALL have port data_in  input  4*N: N hex nibbles, digit i = data_in[4i+3:4i].
REQ-008 SHALL have port an  output  N: digit enables, active-low, registered.
REQ-009 SHALL have port seg  output  7: segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-010 SHALL have port frame_done  output  1: one-cycle pulse at end of each full scan.

Function
REQ-011 SHALL run a prescaler counting 0..DIV-1 and wrapping to 0; tick = 1 in the cycle the prescaler equals DIV-1.
REQ-012 SHALL hold a K-bit scan index that advances by 1 on each tick, wrapping from N-1 to 0.
REQ-013 SHALL pulse frame_done high for exactly one cycle, registered, in the cycle after the index wraps N-1 -> 0.
REQ-014 SHALL capture data_in into a pending register and set pending_valid when load=1; with back-to-back loads, the last one wins.
REQ-015 SHALL copy pending into the display register and clear pending_valid only on a wrap tick (index N-1 -> 0), so a frame never mixes old and new data.
REQ-016 SHALL, when load=1 in the same cycle as a wrap tick, write data_in directly into the display register and leave pending_valid at 0.
REQ-017 SHALL register an and seg from the current index and display register with 1-cycle latency: an[idx]=0, all other an bits 1.
REQ-018 SHALL decode each nibble to hex with active-low encoding: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, A=0x08, b=0x03, C=0x46, d=0x21, E=0x06, F=0x0E.
REQ-019 SHALL never assert more than one an bit low in any cycle.

Reset
REQ-020 SHALL, while RST=0 at a rising CLK edge, clear the prescaler, index, display, pending and pending_valid, set an to all 1s and seg to 0x7F, and drive frame_done to 0.
REQ-021 SHALL let reset override load and tick in the same cycle, and discard any pending data when reset is applied mid-frame.
REQ-022 SHALL start the first tick DIV cycles after RST deasserts, with index 0 shown from the first cycle after release.

Configuration
REQ-023 SHALL support macro SEG_LZ_BLANK_EN: when defined, digits above the highest nonzero nibble output seg=0x7F, and digit 0 is never blanked; when undefined, all digits display normally, including leading zeros.

Verification (use DIV=4, N=8)
REQ-024 SHALL verify: reset, then hold RST=1 for 40 cycles -> an steps 0xFE, 0xFD, ... 0x7F every 4 cycles, then wraps to 0xFE, with frame_done high for 1 cycle after the wrap.
REQ-025 SHALL verify: load data_in=0x76543210 at index 3 -> the old value is displayed until the wrap, then digit i shows i (digit 0 seg=0x40, digit 7 seg=0x78).
REQ-026 SHALL verify: load=1 coincident with a wrap tick using 0xFEDCBA98 -> next frame digit 0 seg=0x00 and digit 7 seg=0x0E, with pending_valid=0.
REQ-027 SHALL verify: two loads (0x11111111, then 0x22222222) within one frame -> the next frame shows only 2 (seg=0x24).
REQ-028 SHALL verify: RST=0 asserted at index 5 with a load pending -> next cycle an=0xFF, seg=0x7F; after release, the display shows 0 and the pending data is lost.
REQ-029 SHALL verify: with SEG_LZ_BLANK_EN defined, display 0x00000305 -> digits 3-7 show seg=0x7F, digit 1 shows 0x40, digit 2 shows 0x30; with display 0x00000000, digit 0 shows 0x40.
